// File: rtl/qpsk_carrier_mod.sv
// QPSK carrier modulator: captures dibits on in_valid rising edges, Gray-maps them to a
// carrier phase offset and plays a 16-step sine LUT, switching symbols only at period wraps.
module qpsk_carrier_mod #(
  parameter int DW       = 8,
  parameter int CARR_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           in_dibit,
  output logic signed [DW-1:0] mod_out,
  output logic                 out_valid,
  output logic [1:0]           phase_sel,
  output logic                 sym_strobe,
  output logic                 overrun,
  output logic                 underrun
);

  localparam int CW = (CARR_DIV > 1) ? $clog2(CARR_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CARR_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic            in_valid_d;
  logic [1:0]      pend_sym;
  logic            pend_flag;
  logic [3:0]      carr_idx;
  logic [CW-1:0]   div_cnt;

  logic            rise;
  logic            boundary;
  logic            load;
  logic [3:0]      idx;
  logic signed [7:0]    lut_val;
  logic signed [DW-1:0] samp;

  // Gray mapping: adjacent phases differ in one bit, 90 degrees = 4 LUT steps.
  function automatic logic [3:0] phase_off(input logic [1:0] sym);
    case (sym)
      2'b00:   phase_off = 4'd2;
      2'b01:   phase_off = 4'd6;
      2'b11:   phase_off = 4'd10;
      default: phase_off = 4'd14;
    endcase
  endfunction

  function automatic logic signed [7:0] sine_lut(input logic [3:0] i);
    case (i)
      4'd0:    sine_lut = 8'sd0;
      4'd1:    sine_lut = 8'sd49;
      4'd2:    sine_lut = 8'sd90;
      4'd3:    sine_lut = 8'sd117;
      4'd4:    sine_lut = 8'sd127;
      4'd5:    sine_lut = 8'sd117;
      4'd6:    sine_lut = 8'sd90;
      4'd7:    sine_lut = 8'sd49;
      4'd8:    sine_lut = 8'sd0;
      4'd9:    sine_lut = -8'sd49;
      4'd10:   sine_lut = -8'sd90;
      4'd11:   sine_lut = -8'sd117;
      4'd12:   sine_lut = -8'sd127;
      4'd13:   sine_lut = -8'sd117;
      4'd14:   sine_lut = -8'sd90;
      default: sine_lut = -8'sd49;
    endcase
  endfunction

  assign rise     = in_valid & ~in_valid_d;
  assign boundary = (state == RUN) && (carr_idx == 4'd15) && (div_cnt == DIV_LAST);
  // A pending dibit is taken either on the first cycle in IDLE or at a period wrap.
  assign load     = pend_flag && ((state == IDLE) || boundary);
  assign idx      = carr_idx + phase_off(phase_sel);
  assign lut_val  = sine_lut(idx);
  assign samp     = DW'(lut_val) <<< (DW - 8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_valid_d <= 1'b0;
      pend_sym   <= 2'b00;
      pend_flag  <= 1'b0;
      carr_idx   <= 4'd0;
      div_cnt    <= '0;
      mod_out    <= '0;
      out_valid  <= 1'b0;
      phase_sel  <= 2'b00;
      sym_strobe <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      in_valid_d <= in_valid;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= rise && pend_flag && !load;
      pend_flag  <= rise || (pend_flag && !load);
      if (rise) pend_sym <= in_dibit;

      case (state)
        IDLE: begin
          carr_idx  <= 4'd0;
          div_cnt   <= '0;
          mod_out   <= '0;
          out_valid <= 1'b0;
          if (pend_flag) begin
            phase_sel  <= pend_sym;
            sym_strobe <= 1'b1;
            state      <= RUN;
          end
        end
        default: begin
          out_valid <= 1'b1;
          mod_out   <= samp;
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            carr_idx <= carr_idx + 4'd1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (boundary) begin
            if (pend_flag) begin
              phase_sel  <= pend_sym;
              sym_strobe <= 1'b1;
            end else begin
              underrun <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_carrier_mod.sv
// Scoreboard bench for qpsk_carrier_mod: per-tick expectations are queued from the
// scenario plan, then popped and compared against a DW=8 and a DW=12 instance.
module tb_qpsk_carrier_mod;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] in_dibit = 2'b00;

  logic signed [7:0]  mod_out;
  logic               out_valid, sym_strobe, overrun, underrun;
  logic [1:0]         phase_sel;
  logic signed [11:0] mod_out12;
  logic               out_valid12, sym_strobe12, overrun12, underrun12;
  logic [1:0]         phase_sel12;

  always #5 clk = ~clk;

  qpsk_carrier_mod #(.DW(8), .CARR_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dibit(in_dibit),
    .mod_out(mod_out), .out_valid(out_valid), .phase_sel(phase_sel),
    .sym_strobe(sym_strobe), .overrun(overrun), .underrun(underrun)
  );

  qpsk_carrier_mod #(.DW(12), .CARR_DIV(4)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dibit(in_dibit),
    .mod_out(mod_out12), .out_valid(out_valid12), .phase_sel(phase_sel12),
    .sym_strobe(sym_strobe12), .overrun(overrun12), .underrun(underrun12)
  );

  typedef struct packed {
    logic        vld;
    logic        strobe;
    logic        under;
    logic        over;
    logic [1:0]  ph;
    logic [7:0]  s;
    logic        vld12;
    logic        strobe12;
    logic        under12;
    logic        over12;
    logic [1:0]  ph12;
    logic [11:0] s12;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   g_rise[4];
  logic [1:0] g_dib[4];
  int   lut_tb[16] = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};

  function automatic exp_t observe();
    return {out_valid, sym_strobe, underrun, overrun, phase_sel, mod_out,
            out_valid12, sym_strobe12, underrun12, overrun12, phase_sel12, mod_out12};
  endfunction

  function automatic int off_tb(input logic [1:0] s);
    case (s)
      2'b00:   return 2;
      2'b01:   return 6;
      2'b11:   return 10;
      default: return 14;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_dibit = 2'b00;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Queue expected outputs per tick: tick 0 = edge that samples the first rise.
  task automatic plan(input logic [1:0] syms[4], input int nper, input int ntick,
                      input int rises[4], input logic [1:0] dibs[4], input int ov_tick);
    exp_t e;
    sb.delete();
    g_rise = rises;
    g_dib  = dibs;
    for (int i = 0; i < ntick; i++) begin
      e = '0;
      if (i == 1) begin
        e.strobe = 1'b1;
        e.ph = syms[0];
      end else if (i >= 2) begin
        int k = i - 2;
        int p = k / 64;
        int v;
        logic [1:0] cs;
        cs = syms[(p < nper) ? p : nper - 1];
        v = lut_tb[((k / 4) % 16 + off_tb(cs)) % 16];
        e.vld = 1'b1;
        e.s = 8'(v);
        e.ph = cs;
        if (k % 64 == 63) begin
          if (p + 1 < nper) begin
            e.strobe = 1'b1;
            e.ph = syms[p + 1];
          end else begin
            e.under = 1'b1;
          end
        end
      end
      e.over = (i == ov_tick);
      e.vld12 = e.vld;
      e.strobe12 = e.strobe;
      e.under12 = e.under;
      e.over12 = e.over;
      e.ph12 = e.ph;
      e.s12 = (i >= 2) ? 12'(int'($signed(e.s)) * 16) : 12'd0;
      sb.push_back(e);
    end
  endtask

  task automatic drive(input int i);
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++)
      if (g_rise[j] >= 0 && i >= g_rise[j] && i <= g_rise[j] + 1) begin
        in_valid = 1'b1;
        in_dibit = g_dib[j];
      end
  endtask

  task automatic test_reset();
    exp_t obs;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_dibit = 2'($urandom_range(0, 3));
      tick();
      obs = observe();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_hold i=%0d got %h want 0", i, obs); end
    end
    in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      obs = observe();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_idle i=%0d got %h want 0", i, obs); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t obs;
    do_reset();
    g_rise = '{0, 20, -1, -1};
    g_dib  = '{2'b01, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 24; i++) begin drive(i); tick(); end
    in_valid = 1'b1;
    #3 rst = 1'b0;
    #1;
    obs = observe();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_async got %h want 0", obs); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      obs = observe();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_release i=%0d got %h want 0", i, obs); end
    end
    in_valid = 1'b1;
    in_dibit = 2'b11;
    tick();
    tick();
    checks++;
    if ({sym_strobe, phase_sel} !== 3'b111) begin
      errors++; $display("FAIL reset_restart got %b want 111", {sym_strobe, phase_sel});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    exp_t obs, e;
    do_reset();
    plan('{2'b00, 2'b00, 2'b00, 2'b00}, 1, 72, '{0, -1, -1, -1},
         '{2'b00, 2'b00, 2'b00, 2'b00}, -1);
    for (int i = 0; i < 72; i++) begin
      drive(i); tick();
      e = sb.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin errors++; $display("FAIL single i=%0d got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_sequence();
    exp_t obs, e;
    do_reset();
    plan('{2'b00, 2'b01, 2'b11, 2'b10}, 4, 258, '{0, 64, 128, 192},
         '{2'b00, 2'b01, 2'b11, 2'b10}, -1);
    for (int i = 0; i < 258; i++) begin
      drive(i); tick();
      e = sb.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sequence i=%0d got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_overrun();
    exp_t obs, e;
    do_reset();
    plan('{2'b00, 2'b11, 2'b11, 2'b11}, 2, 74, '{0, 10, 30, -1},
         '{2'b00, 2'b01, 2'b11, 2'b00}, 30);
    for (int i = 0; i < 74; i++) begin
      drive(i); tick();
      e = sb.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin errors++; $display("FAIL overrun i=%0d got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t obs, e;
    do_reset();
    plan('{2'b00, 2'b01, 2'b11, 2'b11}, 3, 134, '{0, 40, 65, -1},
         '{2'b00, 2'b01, 2'b11, 2'b00}, -1);
    for (int i = 0; i < 134; i++) begin
      drive(i); tick();
      e = sb.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin errors++; $display("FAIL boundary_rise i=%0d got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_dw12();
    exp_t obs, e;
    int mx, mn;
    mx = 0; mn = 0;
    do_reset();
    plan('{2'b10, 2'b10, 2'b10, 2'b10}, 1, 70, '{0, -1, -1, -1},
         '{2'b10, 2'b00, 2'b00, 2'b00}, -1);
    for (int i = 0; i < 70; i++) begin
      drive(i); tick();
      e = sb.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin errors++; $display("FAIL dw12 i=%0d got %h want %h", i, obs, e); end
      if (int'(mod_out12) > mx) mx = int'(mod_out12);
      if (int'(mod_out12) < mn) mn = int'(mod_out12);
    end
    checks++;
    if (mx != 2032) begin errors++; $display("FAIL dw12_peak got %0d want 2032", mx); end
    checks++;
    if (mn != -2032) begin errors++; $display("FAIL dw12_trough got %0d want -2032", mn); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_overrun();
    test_back_to_back();
    test_dw12();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
